bp_stream_axil_host: RTL
========================

BP_STREAM_AXIL_HOST -- requirements
Module: bp_stream_axil_host

Interface
REQ-001 Parameter stream_addr_width_p, default 32: stream and AXI-Lite address width.
REQ-002 Parameter stream_data_width_p, default 32: stream and AXI-Lite data width.
REQ-003 Parameter rsp_fifo_els_p, default 4: response FIFO depth, at least 2.
REQ-004 clk_i  in  1: single clock; all logic is rising-edge.
REQ-005 reset_n_i  in  1: asynchronous, active-low reset.
REQ-006 s_axil_aw{addr,prot,valid}_i / s_axil_awready_o  in/out  addr,3,1 / 1: host write-address channel.
REQ-007 s_axil_w{data,strb,valid}_i / s_axil_wready_o  in/out  data,data/8,1 / 1: host write-data channel.
REQ-008 s_axil_b{resp,valid}_o / s_axil_bready_i  out/in  2,1 / 1: write response.
REQ-009 s_axil_ar{addr,prot,valid}_i / s_axil_arready_o  in/out  addr,3,1 / 1: host read-address channel.
REQ-010 s_axil_r{data,resp,valid}_o / s_axil_rready_i  out/in  data,2,1 / 1: read-data channel.
REQ-011 stream_v_o, stream_addr_o, stream_data_o  out  1,addr,data: outbound stream word toward the BP stream host.
REQ-012 stream_yumi_i  in  1: consumer accepted the outbound word this cycle.
REQ-013 stream_v_i, stream_data_i  in  1,data: inbound stream word from the BP stream host.
REQ-014 stream_ready_o  out  1: block can accept an inbound word.

Function
REQ-015 Write FSM states: W_COLLECT, W_STREAM, W_RESP; one write outstanding at a time.
REQ-016 W_COLLECT: awready_o=1 until AW is captured and wready_o=1 until W is captured; AW and W may arrive in either order or in the same cycle.
REQ-017 When both are captured, go to W_STREAM; stream_v_o=1 with the captured address and data, held stable until stream_yumi_i.
REQ-018 On stream_yumi_i, go to W_RESP; bvalid_o=1 and bresp_o=OKAY (2'b00) are held until bready_i; then return to W_COLLECT.
REQ-019 stream_yumi_i without stream_v_o is ignored.
REQ-020 Response FIFO: push when stream_v_i & stream_ready_o; stream_ready_o = ~full; occupancy counter width is clog2(rsp_fifo_els_p+1).
REQ-021 Read FSM states: R_IDLE, R_RESP; arready_o=1 only in R_IDLE; rvalid_o asserts the cycle after the AR handshake and is held until rready_i.
REQ-022 Read decode on araddr[7:0]: 0x00 returns the FIFO head and pops it on the R handshake; 0x04 returns occupancy, zero-extended; any other address returns 0 with rresp=SLVERR (2'b10).
REQ-023 A read of 0x00 with the FIFO empty returns rdata=0 and rresp=SLVERR, and does not pop.
REQ-024 Rdata is sampled at the AR handshake and held stable while rvalid_o=1.
REQ-025 A push and a pop in the same cycle leave occupancy unchanged; the FIFO wraps at rsp_fifo_els_p.
REQ-026 The write and read paths operate concurrently and independently.
REQ-027 awprot and arprot are ignored.

Reset
REQ-028 While reset_n_i=0: both FSMs are idle; the FIFO is empty; stream_v_o, bvalid_o, rvalid_o, stream_ready_o, awready_o, wready_o and arready_o are 0; data outputs are 0.
REQ-029 On the first clock edge after deassertion, stream_ready_o, awready_o, wready_o and arready_o rise to 1.
REQ-030 Reset asserted mid-transaction drops in-flight state immediately, without completing the stream or AXI handshakes.

Configuration
REQ-031 Macro BP_STREAM_AXIL_HOST_STRB_CHECK_EN, when defined: a write with wstrb not all ones skips W_STREAM and goes directly to W_RESP with bresp=SLVERR.
REQ-032 Without the macro, wstrb is ignored and every write is forwarded with OKAY.

Verification
REQ-033 AW 0x10 and W 0xDEADBEEF in the same cycle, yumi after 3 cycles -> stream_v_o held 3 cycles with addr 0x10 and data 0xDEADBEEF; then bvalid with OKAY.
REQ-034 W arrives 2 cycles before AW 0x20 -> a single stream word with addr 0x20; no second awready during W_STREAM.
REQ-035 Push 4 words 1..4 with rsp_fifo_els_p=4 -> stream_ready_o=0; read 0x04 returns 4; reads of 0x00 return 1,2,3,4; a fifth read returns 0 with SLVERR.
REQ-036 Read 0x00 popping while stream_v_i pushes at occupancy 2 in the same cycle -> occupancy stays 2 and FIFO order is preserved.
REQ-037 With the macro defined, wstrb=4'b0011 -> no stream_v_o and bresp=SLVERR; without the macro -> the word is forwarded with OKAY.
REQ-038 reset_n_i pulsed low while in W_STREAM -> stream_v_o drops asynchronously; after release, a new write completes normally.

Source files
------------

// File: rtl/bp_stream_axil_host_if.sv
// ----------------------------------------------------------------------------
// bp_stream_axil_host_if
//
// AXI-Lite bundle between a host (master) and bp_stream_axil_host (slave).
// Signals are named after their AXI-Lite channel role. Direction comes from
// the modport, so the names carry no _i/_o suffix.
//
// Parameters
//   addr_width_p : width of awaddr/araddr
//   data_width_p : width of wdata/rdata (wstrb is data_width_p/8 bits)
//
// Channels
//   AW : awaddr, awprot, awvalid -> / <- awready
//   W  : wdata, wstrb, wvalid    -> / <- wready
//   B  : <- bresp, bvalid        / bready ->
//   AR : araddr, arprot, arvalid -> / <- arready
//   R  : <- rdata, rresp, rvalid / rready ->
// ----------------------------------------------------------------------------
interface bp_stream_axil_host_if #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
);
    logic [addr_width_p-1:0]   awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;

    logic [data_width_p-1:0]   wdata;
    logic [data_width_p/8-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;

    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    logic [addr_width_p-1:0]   araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;

    logic [data_width_p-1:0]   rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/bp_stream_axil_host.sv
// ----------------------------------------------------------------------------
// bp_stream_axil_host
//
// This block bridges an AXI-Lite host onto a BP stream host.
// - Write path: it collects AW and W in either order, forwards the pair as
//   one outbound stream word, then returns a B response. Only one write is
//   outstanding at a time.
// - Read path: inbound stream words queue in a response FIFO.
//     read 0x00 -> FIFO head; the entry is popped on the R handshake
//     read 0x04 -> occupancy
//   An empty 0x00 read or any other address returns 0 with SLVERR.
// The two paths run independently. awprot and arprot are ignored.
//
// Optional feature (macro BP_STREAM_AXIL_HOST_STRB_CHECK_EN):
//   When the macro is defined, a write whose wstrb is not all ones is not
//   forwarded and completes with SLVERR. The default build ignores wstrb.
//
// Ports
//   clk_i, reset_n_i   : clock, asynchronous active-low reset
//   s_axil             : AXI-Lite slave (bp_stream_axil_host_if.slave)
//   stream_v_o/addr_o/data_o, stream_yumi_i : outbound word, consumer accept
//   stream_v_i/data_i, stream_ready_o       : inbound word, FIFO not full
// ----------------------------------------------------------------------------
module bp_stream_axil_host #(
    parameter int stream_addr_width_p = 32,
    parameter int stream_data_width_p = 32,
    parameter int rsp_fifo_els_p      = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    bp_stream_axil_host_if.slave           s_axil,

    output logic                           stream_v_o,
    output logic [stream_addr_width_p-1:0] stream_addr_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_yumi_i,

    input  logic                           stream_v_i,
    input  logic [stream_data_width_p-1:0] stream_data_i,
    output logic                           stream_ready_o
);

    localparam int          cnt_w_lp  = $clog2(rsp_fifo_els_p + 1);
    localparam int          ptr_w_lp  = (rsp_fifo_els_p > 1) ? $clog2(rsp_fifo_els_p) : 1;
    localparam logic [1:0]  okay_lp   = 2'b00;
    localparam logic [1:0]  slverr_lp = 2'b10;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_COLLECT, W_STREAM, W_RESP} wr_state_e;

    wr_state_e                      wr_state_q;
    logic                           awready_q, wready_q;
    logic                           aw_got_q, w_got_q;
    logic                           stream_v_q, bvalid_q;
    logic [1:0]                     bresp_q;
    logic [stream_addr_width_p-1:0] waddr_q;
    logic [stream_data_width_p-1:0] wdata_q;

    logic aw_hs, w_hs, aw_got, w_got;

    assign aw_hs  = s_axil.awvalid & awready_q;
    assign w_hs   = s_axil.wvalid & wready_q;
    // A channel counts as captured if it was taken earlier or is taken now.
    assign aw_got = aw_got_q | aw_hs;
    assign w_got  = w_got_q | w_hs;

`ifdef BP_STREAM_AXIL_HOST_STRB_CHECK_EN
    logic [stream_data_width_p/8-1:0] wstrb_q;
    logic [stream_data_width_p/8-1:0] wstrb_eff;
    assign wstrb_eff = w_hs ? s_axil.wstrb : wstrb_q;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_state_q <= W_COLLECT;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            stream_v_q <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= okay_lp;
            waddr_q    <= '0;
            wdata_q    <= '0;
`ifdef BP_STREAM_AXIL_HOST_STRB_CHECK_EN
            wstrb_q    <= '0;
`endif
        end else begin
            case (wr_state_q)
                W_COLLECT: begin
                    if (aw_hs) waddr_q <= s_axil.awaddr;
                    if (w_hs) begin
                        wdata_q <= s_axil.wdata;
`ifdef BP_STREAM_AXIL_HOST_STRB_CHECK_EN
                        wstrb_q <= s_axil.wstrb;
`endif
                    end
                    if (aw_got && w_got) begin
                        aw_got_q  <= 1'b0;
                        w_got_q   <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
`ifdef BP_STREAM_AXIL_HOST_STRB_CHECK_EN
                        if (wstrb_eff != '1) begin
                            // A partial-strobe write is not forwarded.
                            wr_state_q <= W_RESP;
                            bvalid_q   <= 1'b1;
                            bresp_q    <= slverr_lp;
                        end else begin
                            wr_state_q <= W_STREAM;
                            stream_v_q <= 1'b1;
                        end
`else
                        wr_state_q <= W_STREAM;
                        stream_v_q <= 1'b1;
`endif
                    end else begin
                        // Readies also rise here on the first edge after reset.
                        aw_got_q  <= aw_got;
                        w_got_q   <= w_got;
                        awready_q <= ~aw_got;
                        wready_q  <= ~w_got;
                    end
                end
                W_STREAM: begin
                    if (stream_yumi_i) begin
                        stream_v_q <= 1'b0;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= okay_lp;
                        wr_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axil.bready) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_COLLECT;
                    end
                end
                default: wr_state_q <= W_COLLECT;
            endcase
        end
    end

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign stream_v_o     = stream_v_q;
    assign stream_addr_o  = waddr_q;
    assign stream_data_o  = wdata_q;

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [stream_data_width_p-1:0] mem_q [rsp_fifo_els_p];
    logic [ptr_w_lp-1:0]            wr_ptr_q, rd_ptr_q;
    logic [cnt_w_lp-1:0]            count_q, count_d;
    logic                           stream_ready_q;
    logic                           push, pop, fifo_empty;

    assign push       = stream_v_i & stream_ready_q;
    assign fifo_empty = (count_q == '0);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + cnt_w_lp'(1);
        else if (pop && !push) count_d = count_q - cnt_w_lp'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            stream_ready_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            // Registered "not full" flag, computed from next-state occupancy.
            stream_ready_q <= (count_d != cnt_w_lp'(rsp_fifo_els_p));
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == ptr_w_lp'(rsp_fifo_els_p - 1)) ? '0 : wr_ptr_q + ptr_w_lp'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == ptr_w_lp'(rsp_fifo_els_p - 1)) ? '0 : rd_ptr_q + ptr_w_lp'(1);
            end
        end
    end

    // NOTE: the storage array has no reset. Validity is tracked by
    // count_q/pointers, and a reset-free array maps onto plain RAM/flops.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= stream_data_i;
    end

    assign stream_ready_o = stream_ready_q;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    typedef enum logic {R_IDLE, R_RESP} rd_state_e;

    rd_state_e                      rd_state_q;
    logic                           arready_q, rvalid_q, pop_arm_q;
    logic [1:0]                     rresp_q;
    logic [stream_data_width_p-1:0] rdata_q;

    logic                           ar_hs, r_hs;
    logic [stream_data_width_p-1:0] rdata_d;
    logic [1:0]                     rresp_d;
    logic                           pop_arm_d;

    assign ar_hs = s_axil.arvalid & arready_q;
    assign r_hs  = rvalid_q & s_axil.rready;
    // The head read at AR stays valid until R: only this path pops.
    assign pop   = r_hs & pop_arm_q;

    always_comb begin
        rdata_d   = '0;
        rresp_d   = slverr_lp;
        pop_arm_d = 1'b0;
        case (s_axil.araddr[7:0])
            8'h00: begin
                if (!fifo_empty) begin
                    rdata_d   = mem_q[rd_ptr_q];
                    rresp_d   = okay_lp;
                    pop_arm_d = 1'b1;
                end
            end
            8'h04: begin
                rdata_d = stream_data_width_p'(count_q);
                rresp_d = okay_lp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            pop_arm_q  <= 1'b0;
            rresp_q    <= okay_lp;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= rdata_d;
                        rresp_q    <= rresp_d;
                        pop_arm_q  <= pop_arm_d;
                        rd_state_q <= R_RESP;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axil.rready) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        pop_arm_q  <= 1'b0;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;

    // Inputs with no function in this block, gathered into one sink.
    logic unused_inputs;
`ifdef BP_STREAM_AXIL_HOST_STRB_CHECK_EN
    assign unused_inputs = ^{s_axil.awprot, s_axil.arprot, s_axil.araddr};
`else
    assign unused_inputs = ^{s_axil.awprot, s_axil.arprot, s_axil.araddr, s_axil.wstrb};
`endif

endmodule
